ccsds_turbo_enc_punct_ser: RTL and testbench
============================================

Name: ccsds_turbo_enc_punct_ser

Overview:
Runtime-rate puncturing, multiplexing and serialising output stage for the CCSDS turbo encoder. It takes per-symbol outputs from both constituent RSC encoders ({s,1,2,3} each) and applies the puncture/multiplex pattern selected per frame (1/2, 1/3, 1/4 or 1/6). Selected bits are buffered in a small symbol FIFO and emitted as a framed 1-bit stream with valid/ready backpressure. It replaces the fixed compile-time-rate combinational output mux and is the output FIFO stage of the encoder top.

Parameters:
K, 8160, information bits per frame; frame = K+4 symbols, including the termination symbols.
DEPTH, 16, FIFO depth in symbol entries; power of two, minimum 4.
CNT_W, $clog2(6*(K+4)+1), width of the frame bit counter.

Ports:
clk  in  1  single clock domain.
rstn  in  1  asynchronous active-low reset.
i_rate_sel  in  2  rate select: 00=1/2, 01=1/3, 10=1/4, 11=1/6. Sampled at the first symbol of each frame.
i_sym_valid  in  1  symbol present on i_rsc1_sym/i_rsc2_sym.
o_sym_ready  out  1  symbol accepted when i_sym_valid & o_sym_ready.
i_rsc1_sym  in  4  {s,1a,2a,3a}, MSB first.
i_rsc2_sym  in  4  {s',1b,2b,3b}, MSB first.
o_data  out  1  serial coded bit.
o_valid  out  1  o_data is valid.
i_ready  in  1  downstream accepts the bit when o_valid & i_ready.
o_sof  out  1  first bit of the codeword; qualified by o_valid.
o_eof  out  1  last bit of the codeword; qualified by o_valid.
o_overflow  out  1  sticky: i_sym_valid was high while o_sym_ready was low.
o_busy  out  1  a frame is in progress, or the FIFO or serialiser is not empty.

Behaviour:
- Reset values: o_valid, o_data, o_sof, o_eof, o_overflow and o_busy are 0. o_sym_ready is 1. FIFO is empty, counters are 0, latched rate is 00, FSM is in IDLE.
- Input stage:
  - Symbol counter sym_idx runs 0..K+3 and wraps to 0 after K+3.
  - At sym_idx==0 the rate is latched from i_rate_sel. i_rate_sel changes mid-frame are ignored.
  - Selected bits per accepted symbol, MSB first:
    - 1/2, even sym_idx: {0a,1a}
    - 1/2, odd sym_idx: {0a,1b}
    - 1/3: {0a,1a,1b}
    - 1/4: {0a,2a,3a,1b}
    - 1/6: {0a,1a,2a,3a,1b,3b}
  - The puncture phase is the LSB of sym_idx, so it restarts every frame.
- FIFO entry is {sof, eof, n[2:0], bits[5:0]}, with bits left-aligned. sof is set when sym_idx==0; eof is set when sym_idx==K+3.
- o_sym_ready = !fifo_full. The write happens on the accepting edge.
- If i_sym_valid is high while full, nothing is written, the counter does not advance, and o_overflow is set. o_overflow is cleared only by reset.
- Serialiser FSM:
  - IDLE: if the FIFO is not empty, pop an entry into the shift register, set bit_cnt=n, go to SHIFT.
  - SHIFT: o_valid=1 and o_data=sr[5].
    - On handshake, shift left and decrement bit_cnt.
    - If the last bit is handshaken and the FIFO is not empty, pop and reload in the same cycle (no bubble). If the FIFO is empty, go to IDLE.
  - o_sof is high on bit 0 of an sof entry. o_eof is high on the last bit of an eof entry.
  - Without handshake, o_data, o_sof and o_eof hold stable.
- Latency: a symbol accepted in cycle t with an idle serialiser gives its first bit on o_valid in cycle t+2.
- Throughput: one bit per cycle. Sustained input rate is therefore one symbol per n cycles, enforced through o_sym_ready.
- Codeword length is (K+4)*n bits: n=2, 3, 4 or 6.
- Simultaneous push and pop while full: the pop frees a slot registered for the next cycle. o_sym_ready is not combinationally dependent on i_ready.
- Reset mid-frame: all state is discarded and the next accepted symbol is treated as sym_idx 0.
- o_busy = (sym_idx!=0) | !fifo_empty | (state!=IDLE).

Decomposition:
- Shared package ccsds_turbo_pkg:
  - rate-select encodings RATE_1_2, RATE_1_3, RATE_1_4, RATE_1_6
  - function rate_nbits(sel), returning 2/3/4/6
  - FIFO entry field widths
- One natural sub-module: ccsds_turbo_sync_fifo, a generic single-clock FIFO with DEPTH and width parameters, full/empty flags, and async active-low reset.
- The puncture selection and the serialiser FSM stay in this module.

Test Plan:
All scenarios use K=8 (12 symbols/frame), i_rsc1_sym=4'b1010, i_rsc2_sym=4'b0110 constant, i_ready=1.
- Rate 00, one frame: bits are 1,0,1,1 repeated, 24 bits total. o_sof is on bit 0, o_eof on bit 23, with no gaps.
- Rate 01: 1,0,1 repeated, 36 bits. Rate 10: 1,1,0,1 repeated, 48 bits. Rate 11: 1,0,1,0,1,0 repeated, 72 bits. o_eof only on the final bit in each case.
- Rate change mid-frame: i_rate_sel switches 00→11 at symbol 5. The frame stays 24 bits. The next frame is 72 bits.
- Backpressure: i_ready toggles randomly and input is driven continuously.
  - The bit stream must equal the i_ready=1 golden stream, with o_data held while stalled.
  - o_sym_ready drops when the FIFO is full. o_overflow stays 0.
- Overflow: force i_sym_valid=1 while o_sym_ready=0. o_overflow rises, the symbol is not counted, and the frame is still 24 bits.
- Async reset asserted mid-frame at bit 10: all outputs return to reset values immediately. The next frame starts with o_sof and is correct.

Source files
------------

// File: rtl/ccsds_turbo_pkg.sv
// Shared definitions for the CCSDS turbo encoder output stage:
// rate-select encodings, bits-per-symbol lookup and FIFO entry layout.
package ccsds_turbo_pkg;

  localparam logic [1:0] RATE_1_2 = 2'b00;
  localparam logic [1:0] RATE_1_3 = 2'b01;
  localparam logic [1:0] RATE_1_4 = 2'b10;
  localparam logic [1:0] RATE_1_6 = 2'b11;

  // FIFO entry: {sof, eof, n[2:0], bits[5:0]}, bits left-aligned.
  localparam int ENT_BITS_W = 6;
  localparam int ENT_N_W    = 3;
  localparam int ENT_W      = 2 + ENT_N_W + ENT_BITS_W;

  typedef struct packed {
    logic                  sof;
    logic                  eof;
    logic [ENT_N_W-1:0]    n;
    logic [ENT_BITS_W-1:0] bits;
  } fifo_ent_t;

  // Number of coded bits emitted per input symbol for a given rate.
  function automatic logic [ENT_N_W-1:0] rate_nbits(input logic [1:0] sel);
    logic [ENT_N_W-1:0] n;
    case (sel)
      RATE_1_2: n = 3'd2;
      RATE_1_3: n = 3'd3;
      RATE_1_4: n = 3'd4;
      default:  n = 3'd6;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ccsds_turbo_sync_fifo.sv
// Generic single-clock FIFO with full/empty flags and show-ahead read data.
// Push while full and pop while empty are ignored.
module ccsds_turbo_sync_fifo
  import ccsds_turbo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = ENT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr_en;
  logic             w_rd_en;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr_en = i_push & ~o_full;
  assign w_rd_en = i_pop & ~o_empty;
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

  // Storage array; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  // Read and write pointer update.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ccsds_turbo_enc_punct_ser.sv
// CCSDS turbo encoder output stage: per-frame rate latch, puncture/multiplex
// selection from both RSC encoders, symbol FIFO and 1-bit framed serialiser.
//
// state    | meaning
// ---------|-------------------------------------------------
// ST_IDLE  | shift register empty, waiting for a FIFO entry
// ST_SHIFT | presenting sr[5] on o_data until all n bits are taken
module ccsds_turbo_enc_punct_ser
  import ccsds_turbo_pkg::*;
#(
  parameter int K     = 8160,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(6*(K+4)+1)
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] i_rate_sel,
  input  logic       i_sym_valid,
  output logic       o_sym_ready,
  input  logic [3:0] i_rsc1_sym,
  input  logic [3:0] i_rsc2_sym,
  output logic       o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_sof,
  output logic       o_eof,
  output logic       o_overflow,
  output logic       o_busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [CNT_W-1:0] LAST_SYM = CNT_W'(K + 3);

  logic [CNT_W-1:0]      r_sym_idx;
  logic [1:0]            r_rate;
  logic                  r_overflow;
  logic [0:0]            r_state;
  logic [ENT_BITS_W-1:0] r_sr;
  logic [ENT_N_W-1:0]    r_cnt;
  logic                  r_sof;
  logic                  r_eof;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_accept;
  logic                  w_pop;
  logic                  w_first;
  logic [1:0]            w_rate;
  logic [ENT_BITS_W-1:0] w_bits;
  fifo_ent_t             w_wr_ent;
  fifo_ent_t             w_rd_ent;
  logic [ENT_W-1:0]      w_rd_raw;
  logic                  w_last_bit;
  logic                  w_unused;

  // Named constituent-encoder bits; s' and 2b are never transmitted.
  logic w_a0, w_a1, w_a2, w_a3, w_b1, w_b3;
  assign w_a0 = i_rsc1_sym[3];
  assign w_a1 = i_rsc1_sym[2];
  assign w_a2 = i_rsc1_sym[1];
  assign w_a3 = i_rsc1_sym[0];
  assign w_b1 = i_rsc2_sym[2];
  assign w_b3 = i_rsc2_sym[0];
  assign w_unused = i_rsc2_sym[3] ^ i_rsc2_sym[1];

  assign o_sym_ready = ~w_full;
  assign w_accept    = i_sym_valid & ~w_full;
  assign w_first     = (r_sym_idx == '0);
  // The first symbol of a frame uses the live selection; the rest use the latch.
  assign w_rate      = w_first ? i_rate_sel : r_rate;

  // Puncture/multiplex selection, left-aligned; phase restarts every frame.
  always_comb begin
    w_bits = '0;
    case (w_rate)
      RATE_1_2: w_bits = {w_a0, (r_sym_idx[0] ? w_b1 : w_a1), 4'b0000};
      RATE_1_3: w_bits = {w_a0, w_a1, w_b1, 3'b000};
      RATE_1_4: w_bits = {w_a0, w_a2, w_a3, w_b1, 2'b00};
      default:  w_bits = {w_a0, w_a1, w_a2, w_a3, w_b1, w_b3};
    endcase
  end

  assign w_wr_ent = '{sof:  w_first,
                      eof:  (r_sym_idx == LAST_SYM),
                      n:    rate_nbits(w_rate),
                      bits: w_bits};

  // Frame symbol counter, rate latch and sticky overflow flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sym_idx  <= '0;
      r_rate     <= RATE_1_2;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_first) r_rate <= i_rate_sel;
        r_sym_idx <= (r_sym_idx == LAST_SYM) ? '0 : r_sym_idx + 1'b1;
      end
      if (i_sym_valid & w_full) r_overflow <= 1'b1;
    end
  end

  ccsds_turbo_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_accept),
    .i_wdata (w_wr_ent),
    .i_pop   (w_pop),
    .o_rdata (w_rd_raw),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_rd_ent   = w_rd_raw;
  assign w_last_bit = (r_cnt == 3'd1);

  // Pop from IDLE, or on the final handshake of an entry to avoid a bubble.
  always_comb begin
    w_pop = 1'b0;
    if (r_state == ST_IDLE)
      w_pop = ~w_empty;
    else if (i_ready && w_last_bit)
      w_pop = ~w_empty;
  end

  // Serialiser FSM and shift register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_sr    <= w_rd_ent.bits;
            r_cnt   <= w_rd_ent.n;
            r_sof   <= w_rd_ent.sof;
            r_eof   <= w_rd_ent.eof;
            r_state <= ST_SHIFT;
          end
        end
        default: begin
          if (i_ready) begin
            if (w_last_bit) begin
              if (!w_empty) begin
                r_sr  <= w_rd_ent.bits;
                r_cnt <= w_rd_ent.n;
                r_sof <= w_rd_ent.sof;
                r_eof <= w_rd_ent.eof;
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_sr  <= {r_sr[ENT_BITS_W-2:0], 1'b0};
              r_cnt <= r_cnt - 1'b1;
              r_sof <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign o_valid    = (r_state == ST_SHIFT);
  assign o_data     = o_valid & r_sr[ENT_BITS_W-1];
  assign o_sof      = o_valid & r_sof;
  assign o_eof      = o_valid & r_eof & w_last_bit;
  assign o_overflow = r_overflow;
  assign o_busy     = (r_sym_idx != '0) | ~w_empty | (r_state != ST_IDLE);

endmodule

// File: tb/tb_ccsds_turbo_enc_punct_ser.sv
// Self-checking bench: a queue-based reference model of the puncture rules
// predicts every serial bit, which one compare process checks on handshake.
module tb_ccsds_turbo_enc_punct_ser;

  localparam int K    = 8;
  localparam int NSYM = K + 4;

  typedef struct packed { logic d; logic s; logic e; } exp_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] i_rate_sel = 2'b00;
  logic       i_sym_valid = 1'b0;
  logic       o_sym_ready;
  logic [3:0] i_rsc1_sym = 4'b1010;
  logic [3:0] i_rsc2_sym = 4'b0110;
  logic       o_data, o_valid, o_sof, o_eof, o_overflow, o_busy;
  logic       i_ready = 1'b1;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  logic got[$];
  int   m_idx = 0;
  logic [1:0] m_rate = 2'b00;
  logic m_ovf = 1'b0;
  int   fbits = 0;
  int   last_len = 0;
  logic in_frame = 1'b0;
  logic gap_chk = 1'b0;
  logic prev_stall = 1'b0;
  logic prev_d, prev_s, prev_e;
  logic saw_full = 1'b0;
  int   ready_mode = 0;
  logic abort = 1'b0;

  ccsds_turbo_enc_punct_ser #(.K(K), .DEPTH(16)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_rate_sel  (i_rate_sel),
    .i_sym_valid (i_sym_valid),
    .o_sym_ready (o_sym_ready),
    .i_rsc1_sym  (i_rsc1_sym),
    .i_rsc2_sym  (i_rsc2_sym),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_sof       (o_sof),
    .o_eof       (o_eof),
    .o_overflow  (o_overflow),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Rate table: which encoder bits go out, in order, for one symbol.
  function automatic void model_sym(input logic [1:0] rate, input logic odd,
                                    input logic [3:0] r1, input logic [3:0] r2,
                                    output int n, output logic [5:0] b);
    logic a0, a1, a2, a3, b1, b3;
    a0 = r1[3]; a1 = r1[2]; a2 = r1[1]; a3 = r1[0];
    b1 = r2[2]; b3 = r2[0];
    case (rate)
      2'b00:   begin n = 2; b = {a0, (odd ? b1 : a1), 4'b0}; end
      2'b01:   begin n = 3; b = {a0, a1, b1, 3'b0}; end
      2'b10:   begin n = 4; b = {a0, a2, a3, b1, 2'b0}; end
      default: begin n = 6; b = {a0, a1, a2, a3, b1, b3}; end
    endcase
  endfunction

  always begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       i_ready = 1'b1;
      1:       i_ready = 1'($urandom_range(0, 1));
      default: i_ready = 1'b0;
    endcase
  end

  // Compare process plus model input capture, all on the falling edge.
  always @(negedge clk) begin
    int n;
    logic [5:0] b;
    exp_t e;
    if (!rstn) begin
      q.delete();
      m_idx = 0; m_rate = 2'b00; m_ovf = 1'b0;
      in_frame = 1'b0; prev_stall = 1'b0; fbits = 0;
    end else begin
      check("overflow_flag", int'(o_overflow), int'(m_ovf));
      if (prev_stall)
        check("stall_hold", int'({o_valid, o_data, o_sof, o_eof}),
              int'({1'b1, prev_d, prev_s, prev_e}));
      if (gap_chk && in_frame)
        check("no_gap", int'(o_valid), 1);
      if (o_valid && i_ready) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_bit actual=%0b required=none at %0t", o_data, $time);
        end else begin
          e = q.pop_front();
          check("bit_dse", int'({o_data, o_sof, o_eof}), int'(e));
        end
        got.push_back(o_data);
        if (o_sof) begin fbits = 0; in_frame = 1'b1; end
        fbits++;
        if (o_eof) begin last_len = fbits; in_frame = 1'b0; end
      end
      prev_stall = o_valid && !i_ready;
      prev_d = o_data; prev_s = o_sof; prev_e = o_eof;
      if (!o_sym_ready) saw_full = 1'b1;
      if (i_sym_valid && o_sym_ready) begin
        if (m_idx == 0) m_rate = i_rate_sel;
        model_sym(m_rate, m_idx[0], i_rsc1_sym, i_rsc2_sym, n, b);
        for (int j = 0; j < n; j++)
          q.push_back({b[5-j], (m_idx == 0 && j == 0), (m_idx == NSYM-1 && j == n-1)});
        m_idx = (m_idx == NSYM-1) ? 0 : m_idx + 1;
      end else if (i_sym_valid) begin
        m_ovf = 1'b1;
      end
    end
  end

  task automatic send(input int nsym, input logic [1:0] r0, input logic [1:0] r1,
                      input int sw, input logic ovf, input logic rnd_sym,
                      input logic rnd_gap);
    int sent = 0;
    int cyc = 0;
    while (sent < nsym && !abort) begin
      @(posedge clk); #1;
      i_rate_sel = (sent < sw) ? r0 : r1;
      if (rnd_sym) {i_rsc1_sym, i_rsc2_sym} = 8'($urandom);
      else begin i_rsc1_sym = 4'b1010; i_rsc2_sym = 4'b0110; end
      if (ovf) i_sym_valid = 1'b1;
      else     i_sym_valid = o_sym_ready && (!rnd_gap || $urandom_range(0, 3) != 0);
      @(negedge clk);
      if (i_sym_valid && o_sym_ready) sent++;
      cyc++;
      if (cyc > 20000) begin
        total++; bad++;
        $display("FAIL send_timeout actual=%0d required=%0d", sent, nsym);
        break;
      end
    end
    @(posedge clk); #1;
    i_sym_valid = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    while ((o_busy || q.size() != 0) && c < 3000) begin
      @(negedge clk); #1;
      c++;
    end
    check("drain_in_time", int'(c < 3000), 1);
    check("model_queue_empty", q.size(), 0);
  endtask

  function automatic logic [5:0] first6();
    logic [5:0] f = '0;
    for (int i = 0; i < 6 && i < got.size(); i++) f[5-i] = got[i];
    return f;
  endfunction

  task automatic run_frame(input logic [1:0] r0, input logic [1:0] r1, input int sw,
                           input int exp_len, input logic [5:0] exp6);
    got.delete();
    gap_chk = 1'b1;
    send(NSYM, r0, r1, sw, 1'b0, 1'b0, 1'b0);
    drain();
    gap_chk = 1'b0;
    check("frame_len", last_len, exp_len);
    check("bit_count", got.size(), exp_len);
    check("first6", int'(first6()), int'(exp6));
  endtask

  initial begin
    logic [5:0] pb;
    int pn;
    int mism;
    int c;
    logic [1:0] r;
    logic [3:0] gold;

    // Pin the model's rate table with hand-derived values.
    model_sym(2'b00, 1'b1, 4'b1010, 4'b0110, pn, pb);
    check("pin_r12_odd", int'(pb), int'(6'b110000));
    model_sym(2'b10, 1'b0, 4'b1010, 4'b0110, pn, pb);
    check("pin_r14", int'(pb), int'(6'b110100));
    model_sym(2'b11, 1'b0, 4'b1010, 4'b0110, pn, pb);
    check("pin_r16_n", pn, 6);

    repeat (2) @(negedge clk);
    #1;
    check("rst_outputs", int'({o_valid, o_data, o_sof, o_eof, o_overflow, o_busy, o_sym_ready}),
          int'(7'b0000001));
    @(posedge clk); #2;
    rstn = 1'b1;

    run_frame(2'b00, 2'b00, 99, 24, 6'b101110);
    run_frame(2'b01, 2'b01, 99, 36, 6'b101101);
    run_frame(2'b10, 2'b10, 99, 48, 6'b110111);
    run_frame(2'b11, 2'b11, 99, 72, 6'b101010);

    // Rate switch at symbol 5 must not affect the running frame.
    run_frame(2'b00, 2'b11, 5, 24, 6'b101110);
    run_frame(2'b11, 2'b11, 99, 72, 6'b101010);

    // Random backpressure against the fixed golden 1,0,1,1 stream.
    got.delete();
    saw_full = 1'b0;
    ready_mode = 1;
    send(3*NSYM, 2'b00, 2'b00, 999, 1'b0, 1'b0, 1'b0);
    drain();
    gold = 4'b1011;
    mism = 0;
    for (int i = 0; i < got.size(); i++)
      if (got[i] !== gold[3 - (i % 4)]) mism++;
    check("bp_golden_stream", mism, 0);
    check("bp_bit_count", got.size(), 72);
    check("bp_frame_len", last_len, 24);
    check("bp_ready_dropped", int'(saw_full), 1);

    // Random symbols, rates, input gaps and backpressure.
    for (int f = 0; f < 6; f++) begin
      r = 2'($urandom_range(0, 3));
      send(NSYM, r, r, 99, 1'b0, 1'b1, 1'b1);
      drain();
      check("rnd_frame_len", last_len,
            NSYM * ((r == 2'b00) ? 2 : (r == 2'b01) ? 3 : (r == 2'b10) ? 4 : 6));
    end

    // Overflow: hold the output, keep pushing past full.
    got.delete();
    ready_mode = 2;
    fork
      send(2*NSYM, 2'b00, 2'b00, 999, 1'b1, 1'b0, 1'b0);
      begin
        c = 0;
        while (o_sym_ready && c < 300) begin @(negedge clk); c++; end
        repeat (5) @(negedge clk);
        ready_mode = 0;
      end
    join
    drain();
    check("ovf_sticky", int'(o_overflow), 1);
    check("ovf_frame_len", last_len, 24);
    check("ovf_bit_count", got.size(), 48);

    // Asynchronous reset in the middle of a frame at bit 10.
    got.delete();
    abort = 1'b0;
    fork
      send(NSYM, 2'b00, 2'b00, 99, 1'b0, 1'b0, 1'b0);
      begin
        c = 0;
        while (!(in_frame && fbits >= 10) && c < 500) begin @(negedge clk); #1; c++; end
        check("reach_bit10", int'(c < 500), 1);
        @(posedge clk); #2;
        rstn = 1'b0;
        #1;
        check("midrst_outputs",
              int'({o_valid, o_data, o_sof, o_eof, o_overflow, o_busy, o_sym_ready}),
              int'(7'b0000001));
        abort = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk); #2;
        rstn = 1'b1;
      end
    join
    abort = 1'b0;
    run_frame(2'b00, 2'b00, 99, 24, 6'b101110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
